// File: rtl/otdr_pkg.sv
// Shared types and widths for the OTDR shot sequencer.
package otdr_pkg;

    localparam int unsigned OTDR_PW_W     = 8;
    localparam int unsigned OTDR_SHOT_W   = 16;
    localparam int unsigned OTDR_SETTLE_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StRun,
        StDone
    } otdr_state_e;

    // A shot needs at least one pulse cycle and the pulse must fit inside the period.
    function automatic logic otdr_cfg_ok(input logic [OTDR_PW_W-1:0]   width,
                                         input logic [OTDR_PW_W-1:0]   period,
                                         input logic [OTDR_SHOT_W-1:0] shots);
        return (shots != '0) && (width != '0) && (width <= period);
    endfunction

endpackage

// File: rtl/otdr_cycle_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
module otdr_cycle_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clock,
    input  logic             reset_sync,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset_sync) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/otdr_shot_sequencer.sv
// Sequences one OTDR acquisition: latch config, settle the pulse generator in reset,
// then release it for a fixed number of periods while mirroring its period counter.
module otdr_shot_sequencer
    import otdr_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_sync,
    input  logic                     start,
    input  logic                     abort,
    input  logic [OTDR_PW_W-1:0]     cfg_width,
    input  logic [OTDR_PW_W-1:0]     cfg_period,
    input  logic [OTDR_SHOT_W-1:0]   cfg_shots,
    input  logic [OTDR_SETTLE_W-1:0] cfg_settle,
    output logic                     pt_reset,
    output logic [OTDR_PW_W-1:0]     pt_width,
    output logic [OTDR_PW_W-1:0]     pt_period,
    output logic                     shot_strobe,
    output logic [OTDR_SHOT_W-1:0]   shot_index,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic                     cfg_error
);

    otdr_state_e state_q, state_d;

    logic [OTDR_PW_W-1:0]     pc_q, pc_d;
    logic [OTDR_SHOT_W-1:0]   shot_q, shot_d, shot_inc;
    logic [OTDR_PW_W-1:0]     width_q, period_q;
    logic [OTDR_SHOT_W-1:0]   shots_q;
    logic [OTDR_SETTLE_W-1:0] settle_q;

    logic pt_reset_q, shot_strobe_q, busy_q, done_q, aborted_q, cfg_error_q;

    logic accept, reject, abort_hit;
    logic cnt_load, cnt_dec, cnt_zero;

    assign accept    = (state_q == StIdle) && start && otdr_cfg_ok(cfg_width, cfg_period, cfg_shots);
    assign reject    = (state_q == StIdle) && start && !otdr_cfg_ok(cfg_width, cfg_period, cfg_shots);
    assign abort_hit = (state_q != StIdle) && abort;
    assign shot_inc  = shot_q + OTDR_SHOT_W'(1);

    // Counter is loaded with settle-1 so its zero flag marks the last SETTLE cycle.
    otdr_cycle_counter #(
        .Width (OTDR_SETTLE_W)
    ) u_settle_cnt (
        .clock      (clock),
        .reset_sync (reset_sync),
        .load       (cnt_load),
        .load_value (settle_q - OTDR_SETTLE_W'(1)),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        shot_d   = shot_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StLoad;
                    shot_d  = '0;
                end
            end
            StLoad: begin
                pc_d = '0;
                if (settle_q != '0) begin
                    state_d  = StSettle;
                    cnt_load = 1'b1;
                end else begin
                    state_d = StRun;
                end
            end
            StSettle: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (pc_q == period_q) begin
                    pc_d   = '0;
                    shot_d = shot_inc;
                    if (shot_inc == shots_q) begin
                        state_d = StDone;
                    end
                end else begin
                    pc_d = pc_q + OTDR_PW_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort freezes the shot count at the last completed shot.
        if (abort_hit) begin
            state_d = StIdle;
            shot_d  = shot_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_sync) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            shot_q        <= '0;
            width_q       <= '0;
            period_q      <= '0;
            shots_q       <= '0;
            settle_q      <= '0;
            pt_reset_q    <= 1'b1;
            shot_strobe_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            cfg_error_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            shot_q  <= shot_d;
            if (accept) begin
                width_q  <= cfg_width;
                period_q <= cfg_period;
                shots_q  <= cfg_shots;
                settle_q <= cfg_settle;
            end
            // Outputs are registered from the next state so they line up with it.
            pt_reset_q    <= (state_d != StRun);
            shot_strobe_q <= (state_d == StRun) && (pc_d == '0);
            busy_q        <= (state_d != StIdle);
            done_q        <= (state_d == StDone);
            aborted_q     <= abort_hit;
            cfg_error_q   <= reject;
        end
    end

    assign pt_reset    = pt_reset_q;
    assign pt_width    = width_q;
    assign pt_period   = period_q;
    assign shot_strobe = shot_strobe_q;
    assign shot_index  = shot_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign cfg_error   = cfg_error_q;

endmodule

// File: tb/tb_otdr_shot_sequencer.sv
// Self-checking bench: directed timing table, hand sequences and a randomized run
// checked against a cycle-arithmetic reference model.
module tb_otdr_shot_sequencer;

    logic        clock = 1'b0;
    logic        reset_sync;
    logic        start;
    logic        abort;
    logic [7:0]  cfg_width;
    logic [7:0]  cfg_period;
    logic [15:0] cfg_shots;
    logic [7:0]  cfg_settle;
    logic        pt_reset;
    logic [7:0]  pt_width;
    logic [7:0]  pt_period;
    logic        shot_strobe;
    logic [15:0] shot_index;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        cfg_error;

    otdr_shot_sequencer dut (
        .clock       (clock),
        .reset_sync  (reset_sync),
        .start       (start),
        .abort       (abort),
        .cfg_width   (cfg_width),
        .cfg_period  (cfg_period),
        .cfg_shots   (cfg_shots),
        .cfg_settle  (cfg_settle),
        .pt_reset    (pt_reset),
        .pt_width    (pt_width),
        .pt_period   (pt_period),
        .shot_strobe (shot_strobe),
        .shot_index  (shot_index),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .cfg_error   (cfg_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        pt_reset;
        logic [7:0]  pt_width;
        logic [7:0]  pt_period;
        logic        shot_strobe;
        logic [15:0] shot_index;
        logic        busy;
        logic        done;
        logic        aborted;
        logic        cfg_error;
    } outs_t;

    outs_t got;
    assign got = {pt_reset, pt_width, pt_period, shot_strobe, shot_index,
                  busy, done, aborted, cfg_error};

    typedef struct {
        int w;
        int p;
        int s;
        int se;
        int exp_err;
        int exp_run;
        int exp_done;
        int exp_strobes;
        int exp_idx;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a sequence is described by its start cycle and config only.
    bit m_active;
    int m_t0, m_w, m_p, m_s, m_st, m_idx;
    bit m_abort_flag, m_err_flag;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic check_outs(input string name, input outs_t req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, req);
        end
    endtask

    function automatic outs_t reset_outs();
        outs_t e;
        e = '0;
        e.pt_reset = 1'b1;
        return e;
    endfunction

    task automatic model_reset();
        m_active = 0; m_t0 = 0; m_w = 0; m_p = 0; m_s = 0; m_st = 0; m_idx = 0;
        m_abort_flag = 0; m_err_flag = 0;
    endtask

    function automatic outs_t model_expect();
        outs_t e;
        int rel, rs, len, r;
        e = '0;
        e.pt_width  = 8'(m_w);
        e.pt_period = 8'(m_p);
        e.aborted   = m_abort_flag;
        e.cfg_error = m_err_flag;
        e.pt_reset  = 1'b1;
        if (m_active) begin
            rel    = cyc - m_t0;
            rs     = 2 + m_st;
            len    = m_s * (m_p + 1);
            e.busy = 1'b1;
            if (rel >= rs && rel < rs + len) begin
                r             = rel - rs;
                e.pt_reset    = 1'b0;
                e.shot_strobe = ((r % (m_p + 1)) == 0);
                e.shot_index  = 16'(r / (m_p + 1));
            end else if (rel == rs + len) begin
                e.done       = 1'b1;
                e.shot_index = 16'(m_s);
            end
        end else begin
            e.shot_index = 16'(m_idx);
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_sync = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        tick();
        tick();
        reset_sync = 1'b0;
        model_reset();
        cyc = 0;
        check_outs("reset_values", reset_outs());
    endtask

    // Check this cycle against the model, drive inputs, advance model and clock.
    task automatic step(input bit st, input bit ab, input int w, input int p, input int s,
                        input int se);
        outs_t e;
        int rel, rs, len;
        e = model_expect();
        check_outs("model", e);
        start      = st;
        abort      = ab;
        cfg_width  = 8'(w);
        cfg_period = 8'(p);
        cfg_shots  = 16'(s);
        cfg_settle = 8'(se);
        m_abort_flag = 0;
        m_err_flag   = 0;
        if (m_active) begin
            rel = cyc - m_t0;
            rs  = 2 + m_st;
            len = m_s * (m_p + 1);
            if (ab) begin
                m_active = 0; m_abort_flag = 1; m_idx = int'(e.shot_index);
            end else if (rel == rs + len) begin
                m_active = 0; m_idx = m_s;
            end
        end else if (st) begin
            if (s == 0 || w == 0 || w > p) begin
                m_err_flag = 1;
            end else begin
                m_active = 1; m_t0 = cyc; m_w = w; m_p = p; m_s = s; m_st = se;
            end
        end
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        int run_start, done_cyc, err_cyc, strobes, busy_seen;
        do_reset();
        start      = 1'b1;
        cfg_width  = 8'(v.w);
        cfg_period = 8'(v.p);
        cfg_shots  = 16'(v.s);
        cfg_settle = 8'(v.se);
        tick();
        start     = 1'b0;
        run_start = -1; done_cyc = -1; err_cyc = -1; strobes = 0; busy_seen = 0;
        for (int n = 1; n <= 600; n++) begin
            if (!pt_reset && run_start < 0) run_start = n;
            if (done && done_cyc < 0) done_cyc = n;
            if (cfg_error && err_cyc < 0) err_cyc = n;
            if (shot_strobe) strobes++;
            if (busy) busy_seen = 1;
            tick();
        end
        check("vec_err_cycle", err_cyc, v.exp_err);
        check("vec_run_start", run_start, v.exp_run);
        check("vec_done_cycle", done_cyc, v.exp_done);
        check("vec_strobes", strobes, v.exp_strobes);
        check("vec_shot_index", int'(shot_index), v.exp_idx);
        check("vec_busy_seen", busy_seen, (v.exp_err < 0) ? 1 : 0);
    endtask

    vec_t vecs[7];

    initial begin
        reset_sync = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_width = '0; cfg_period = '0; cfg_shots = '0; cfg_settle = '0;

        //           w  p    s  se err run done strobes idx
        vecs[0] = '{2, 4,   3, 0, -1, 2,  17,  3, 3};
        vecs[1] = '{2, 4,   3, 5, -1, 7,  22,  3, 3};
        vecs[2] = '{5, 4,   3, 0,  1, -1, -1,  0, 0};
        vecs[3] = '{2, 4,   0, 0,  1, -1, -1,  0, 0};
        vecs[4] = '{0, 4,   3, 0,  1, -1, -1,  0, 0};
        vecs[5] = '{1, 255, 2, 0, -1, 2,  514, 2, 2};
        vecs[6] = '{1, 1,   1, 3, -1, 5,  7,   1, 1};
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Abort in the second shot of a 10-shot run, then a normal sequence.
        do_reset();
        step(1, 0, 1, 3, 10, 0);
        repeat (6) step(0, 0, 1, 3, 10, 0);
        step(0, 1, 1, 3, 10, 0);
        check("abort_pulse", int'(aborted), 1);
        check("abort_pt_reset", int'(pt_reset), 1);
        check("abort_shot_index", int'(shot_index), 1);
        check("abort_busy", int'(busy), 0);
        for (int i = 0; i < 5; i++) begin
            check("abort_no_done", int'(done), 0);
            step(0, 0, 1, 3, 10, 0);
        end
        step(1, 0, 2, 4, 3, 0);
        repeat (16) step(0, 0, 2, 4, 3, 0);
        check("rerun_done", int'(done), 1);
        check("rerun_shot_index", int'(shot_index), 3);
        step(0, 0, 2, 4, 3, 0);

        // Start and config changes during RUN are ignored.
        do_reset();
        step(1, 0, 1, 3, 2, 0);
        repeat (3) step(0, 0, 1, 3, 2, 0);
        step(1, 0, 5, 7, 9, 4);
        repeat (5) step(0, 0, 5, 7, 9, 4);
        check("busy_start_done", int'(done), 1);
        check("busy_start_period", int'(pt_period), 3);
        check("busy_start_index", int'(shot_index), 2);
        step(0, 0, 5, 7, 9, 4);

        // Synchronous reset mid-RUN.
        do_reset();
        step(1, 0, 2, 4, 3, 0);
        repeat (4) step(0, 0, 2, 4, 3, 0);
        reset_sync = 1'b1;
        tick();
        check_outs("mid_run_reset", reset_outs());
        reset_sync = 1'b0;
        model_reset();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit st, ab;
            st = m_active ? ($urandom % 8 == 0) : ($urandom % 3 == 0);
            ab = ($urandom % 40 == 0);
            step(st, ab, int'($urandom % 6), int'($urandom % 7), int'($urandom % 5),
                 int'($urandom % 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
